// File: rtl/fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// fir_tap_sequencer : single-MAC time-multiplexed direct-form FIR sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_tap_sequencer #(
  parameter int N     = 16,
  parameter int TAPS  = 8,
  parameter int ACC_W = 35
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N-1:0]     in_data,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic signed [N-1:0]     coef_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    busy
);

  localparam int AW = $clog2(TAPS);
  localparam logic [AW-1:0] c_LAST_TAP = AW'(TAPS - 1);
  localparam logic [AW-1:0] c_K_ONE    = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                  r_state;
  logic signed [N-1:0]     r_hist [TAPS];
  logic signed [N-1:0]     r_coef [TAPS];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_base;
  logic [AW-1:0]           r_k;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_out_data;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_busy;

  logic [AW-1:0]           w_idx;
  logic signed [2*N-1:0]   w_c_ext;
  logic signed [2*N-1:0]   w_x_ext;
  logic signed [2*N-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_accept;
  logic                    w_coef_wr;

  // Tap k reads x[n-k]; the AW-bit subtraction gives the circular wrap.
  assign w_idx      = r_base - r_k;
  assign w_c_ext    = {{N{r_coef[r_k][N-1]}}, r_coef[r_k]};
  assign w_x_ext    = {{N{r_hist[w_idx][N-1]}}, r_hist[w_idx]};
  assign w_prod     = w_c_ext * w_x_ext;
  assign w_prod_ext = {{(ACC_W-2*N){w_prod[2*N-1]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;

  assign w_accept  = in_valid & r_in_ready & (r_state == S_IDLE);
  assign w_coef_wr = coef_we & (r_state == S_IDLE);

  // in_ready is held low through reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        r_hist[i] <= '0;
        r_coef[i] <= '0;
      end
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_base      <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_coef_wr) begin
        r_coef[coef_addr] <= coef_data;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_hist[r_wr_ptr] <= in_data;
            r_base           <= r_wr_ptr;
            r_acc            <= '0;
            r_k              <= '0;
            r_state          <= S_MAC;
            r_in_ready       <= 1'b0;
            r_busy           <= 1'b1;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          r_k   <= r_k + c_K_ONE;
          if (r_k == c_LAST_TAP) begin
            r_out_data  <= w_sum;
            r_wr_ptr    <= r_wr_ptr + c_K_ONE;
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_sequencer : self-checking bench against a sum-of-products model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fir_tap_sequencer;

  localparam int N     = 16;
  localparam int TAPS  = 8;
  localparam int ACC_W = 35;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [N-1:0]     in_data;
  logic                    coef_we;
  logic [2:0]              coef_addr;
  logic signed [N-1:0]     coef_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    busy;

  int n_total = 0;
  int n_bad   = 0;

  // Model: newest sample first, y = sum c[k]*x[n-k], wrapped to ACC_W bits.
  longint mhist [TAPS];
  longint mcoef [TAPS];

  fir_tap_sequencer #(.N(N), .TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint act, input longint exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint model_y();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += mcoef[k] * mhist[k];
    return (s <<< (64 - ACC_W)) >>> (64 - ACC_W);
  endfunction

  function automatic void model_push(input longint x);
    for (int k = TAPS - 1; k > 0; k--) mhist[k] = mhist[k-1];
    mhist[0] = x;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      mhist[k] = 0;
      mcoef[k] = 0;
    end
  endfunction

  function automatic longint dout();
    return longint'(out_data);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    check({tag, "_rst_in_ready"}, longint'(in_ready), 0);
    check({tag, "_rst_out_valid"}, longint'(out_valid), 0);
    check({tag, "_rst_busy"}, longint'(busy), 0);
    check({tag, "_rst_out_data"}, dout(), 0);
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    check({tag, "_post_rst_in_ready"}, longint'(in_ready), 1);
  endtask

  task automatic write_coef(input int addr, input logic signed [N-1:0] val);
    coef_we   = 1'b1;
    coef_addr = 3'(addr);
    coef_data = val;
    tick();
    coef_we = 1'b0;
    mcoef[addr] = longint'(val);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'(k + 1));
  endtask

  // Returns #1 after the acceptance edge.
  task automatic send(input logic signed [N-1:0] x);
    int n = 0;
    in_valid = 1'b1;
    in_data  = x;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    model_push(longint'(x));
  endtask

  task automatic get_result(input string tag, input int delay, input longint exp);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) check({tag, "_timeout"}, 0, 1);
    repeat (delay) tick();
    check(tag, dout(), exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    longint imp_exp [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0};
    longint exp_pending;
    int     cyc, last_acc, nacc;
    logic   acc_now;

    reset = 1'b1; in_valid = 0; in_data = '0; coef_we = 0;
    coef_addr = '0; coef_data = '0; out_ready = 0;
    model_reset();
    #3;
    do_reset("init");

    // Impulse response through the ramp coefficients
    load_ramp();
    for (int i = 0; i < 10; i++) begin
      send(i == 0 ? 16'sd1 : 16'sd0);
      get_result($sformatf("impulse_%0d", i), 0, imp_exp[i]);
    end

    // Latency and handshake timing
    send(16'sd3);
    check("lat_in_ready_low", longint'(in_ready), 0);
    check("lat_busy_high", longint'(busy), 1);
    cyc = 1;
    while (!out_valid && cyc < 30) begin
      tick();
      cyc++;
    end
    cyc--;
    check("lat_edges_to_out_valid", cyc, TAPS);
    check("lat_data", dout(), model_y());
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("lat_in_ready_back", longint'(in_ready), 1);
    check("lat_out_valid_drop", longint'(out_valid), 0);

    // Back-to-back: continuous in_valid and out_ready gives TAPS+2 spacing
    in_valid = 1'b1; out_ready = 1'b1; in_data = 16'($urandom);
    last_acc = 0; nacc = 0; exp_pending = 0;
    for (cyc = 0; cyc < 80 && nacc < 4; cyc++) begin
      if (out_valid) check("b2b_data", dout(), exp_pending);
      acc_now = in_ready;
      if (acc_now) begin
        model_push(longint'(in_data));
        exp_pending = model_y();
        if (nacc > 0) check("b2b_spacing", cyc - last_acc, TAPS + 2);
        last_acc = cyc;
        nacc++;
      end
      tick();
      if (acc_now) in_data = 16'($urandom);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    get_result("b2b_last", 0, exp_pending);

    // Backpressure in HOLD with a pending sample
    send(16'sd1234);
    cyc = 0;
    while (!out_valid && cyc < 30) begin
      tick();
      cyc++;
    end
    exp_pending = model_y();
    in_valid = 1'b1;
    in_data  = -16'sd77;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", longint'(out_valid), 1);
      check("bp_out_data", dout(), exp_pending);
      check("bp_in_ready", longint'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_released", longint'(out_valid), 0);
    send(-16'sd77);
    get_result("bp_pending_result", 0, model_y());

    // Extremes: no wrap at full negative scale
    do_reset("ext");
    for (int k = 0; k < TAPS; k++) write_coef(k, -16'sd32768);
    for (int i = 0; i < TAPS; i++) begin
      send(-16'sd32768);
      get_result($sformatf("ext_neg_%0d", i), 0, (i == TAPS - 1) ? 64'sd8589934592 : model_y());
    end
    do_reset("ext2");
    write_coef(0, 16'sd32767);
    send(-16'sd32768);
    get_result("ext_mixed", 0, -64'sd1073709056);

    // Coefficient write timing
    do_reset("cw");
    load_ramp();
    send(16'sd2);
    repeat (2) tick();
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd5;
    tick();
    coef_we = 1'b0;
    get_result("coef_in_mac_ignored", 0, 2);
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd5;
    send(16'sd2);
    coef_we = 1'b0;
    mcoef[0] = 5;
    get_result("coef_at_accept", 0, 14);

    // Reset mid-MAC aborts and leaves no residue
    send(16'sd7);
    repeat (3) tick();
    do_reset("midmac");
    check("midmac_out_valid", longint'(out_valid), 0);
    load_ramp();
    send(16'sd3);
    get_result("midmac_after", 0, 3);

    // Randomized traffic with coefficient updates and consumer stalls
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) write_coef(int'($urandom_range(0, TAPS - 1)), 16'($urandom));
      send(16'($urandom));
      get_result($sformatf("rand_%0d", i), int'($urandom_range(0, 3)), model_y());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Control-and-datapath sequencer for a time-multiplexed (single-MAC) direct-form FIR filter.
- Accepts one signed sample per transaction over a valid/ready handshake and stores it in a circular sample history.
- Runs one multiply-accumulate per clock across all taps, then presents the filtered result on a valid/ready output.
- Holds a writable coefficient bank; sits between the sample source and the downstream consumer and replaces the fully parallel register-chain FIR where area matters.

## Interface
- N, 16: sample and coefficient width (signed two's complement).
- TAPS, 8: number of taps; power of two, 2..64.
- ACC_W, 35: accumulator/output width; must be ≥ 2·N + log2(TAPS).

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- in_data  in  N  signed input sample x[n].
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  log2(TAPS)  coefficient index k.
- coef_data  in  N  signed coefficient c[k].
- out_valid  out  1  result y[n] available.
- out_ready  in  1  consumer accepts result.
- out_data  out  ACC_W  signed result y[n] = Σ c[k]·x[n−k], k = 0..TAPS−1.
- busy  out  1  high in MAC or HOLD.

## Operation
- Reset (asynchronous, immediate) clears:
  - history, coefficients, write pointer, tap counter and accumulator to 0;
  - state to IDLE;
  - out_valid, out_data and busy to 0.
- in_ready is 0 while reset is high. After reset it is 1.
- FSM states: IDLE, MAC, HOLD.
- IDLE: in_ready = 1, busy = 0.
  - On in_valid & in_ready, write in_data to history[wr_ptr], latch base = wr_ptr, clear acc and k, and go to MAC.
- MAC: one tap per cycle.
  - acc ← acc + sext(c[k] · history[(base − k) mod TAPS]); k ← k + 1.
  - After the tap with k = TAPS−1: out_data ← final sum, wr_ptr ← wr_ptr + 1 (mod TAPS), go to HOLD.
- HOLD: out_valid = 1 and out_data stable.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- History starts at zero, so the first TAPS−1 outputs use zero for absent past samples.
- Arithmetic:
  - Product is 2N-bit signed, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W with no saturation; with the default widths no overflow is possible.
- Coefficient writes:
  - In IDLE, coef_we writes c[coef_addr] at the clock edge.
  - A write at the same edge as a sample acceptance takes effect for that sample's computation.
  - coef_we in MAC or HOLD is ignored; no coefficient change occurs.
- in_valid outside IDLE is ignored (in_ready = 0); the sample is not consumed.
- out_data retains the last result in IDLE. Only out_valid qualifies it.

## Timing
- Acceptance edge E0 is the edge where in_valid & in_ready is sampled high.
- MAC occupies the edges E1..E_TAPS.
- out_valid is high in the cycle following E_TAPS, i.e. TAPS cycles after acceptance.
- Minimum sample interval is TAPS + 2 cycles (accept, TAPS MAC cycles, one HOLD cycle with out_ready = 1). This gives 10 cycles at the defaults.
- in_ready deasserts the cycle after E0 and reasserts the cycle after the HOLD→IDLE edge.
- in_ready, out_valid and busy are decoded from registered state only; there is no combinational path from inputs.
- Reset asserted mid-MAC or mid-HOLD aborts the computation: outputs go to their reset values immediately and the history is cleared.

## Test plan
- Reset, load c = [1,2,3,4,5,6,7,8] in IDLE, then send an impulse x = 1 followed by nine zeros (out_ready = 1) → outputs 1,2,3,4,5,6,7,8,0,0.
- Latency/handshake: accept a sample at edge E0 → in_ready = 0 from E0+1, out_valid = 1 exactly 8 cycles after E0, in_ready = 1 one cycle after the output is taken. Back-to-back in_valid yields a 10-cycle sample spacing.
- Backpressure: hold out_ready = 0 for 5 cycles in HOLD while in_valid = 1 → out_valid and out_data stay constant, in_ready stays 0, no sample is consumed. Releasing out_ready completes the transfer and the pending sample is accepted next.
- Extremes: all c = −32768, eight samples of −32768 → eighth output = 8589934592 (2^33) with no wrap. Also c[0] = 32767, x = −32768 → −1073709056.
- Coefficient timing: coef_we with c[0] = 5 during MAC is ignored (result uses the old c[0]). The same write in IDLE at the acceptance edge of x = 2 → result includes 10 from tap 0.
- Reset mid-MAC: assert reset for 1 cycle at MAC cycle 4 → out_valid = 0, in_ready = 1 after release. A following impulse x = 3 with c = [1,2,…,8] yields 3, confirming no residue from the aborted sample.
